// File: rtl/spi_slave_regfile.sv
`timescale 1ns/1ps
// SPI slave register file, fully synchronous to clk.
// sclk/cs_n/mosi are oversampled through 2-flop synchronisers. Frames are
// CMD(8) ADDR(ADDR_WIDTH) [STRB(STRB_WIDTH)] DATA(DATA_WIDTH)*N, MSB first.
// Writes and reads auto-increment the byte address for bursts.
module spi_slave_regfile #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned NUM_REGS   = 256,
  parameter int unsigned CPOL       = 0,
  parameter int unsigned CPHA       = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        sclk,
  input  logic                        cs_n,
  input  logic                        mosi,
  output logic                        miso,
  output logic                        busy,
  output logic                        wr_pulse,
  output logic [$clog2(NUM_REGS)-1:0] wr_index,
  output logic                        err_pulse
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned IDX_W      = $clog2(NUM_REGS);
  localparam int unsigned BYTE_SH    = $clog2(STRB_WIDTH);
  localparam int unsigned SH_W       = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int unsigned CNT_W      = $clog2(SH_W) + 1;
  localparam logic        IDLE_SCLK  = (CPOL != 0);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, STRB, WDATA, RDATA, IGNORE} state_t;
  state_t state, state_n;

  logic sclk_m, sclk_s, sclk_d;
  logic cs_m, cs_s, cs_d;
  logic mosi_m, mosi_s;
  logic lead_edge, trail_edge, sample_edge, drive_edge, cs_fall;

  logic [CNT_W-1:0]      bit_cnt, field_last;
  logic                  last_bit;
  logic [SH_W-2:0]       sh_in;
  logic [SH_W-1:0]       sh_next;
  logic [7:0]            cmd_byte;
  logic                  cmd_ok;
  logic                  is_write;
  logic [ADDR_WIDTH-1:0] addr, addr_inc, fetch_addr;
  logic [STRB_WIDTH-1:0] strb;
  logic [DATA_WIDTH-1:0] sh_out;
  logic                  miso_q;
  logic [IDX_W-1:0]      w_idx, f_idx;
  logic                  w_ok, f_ok;
  logic [DATA_WIDTH-1:0] mem [NUM_REGS];

  // Two-flop synchronisers plus one delayed copy for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_m <= IDLE_SCLK;
      sclk_s <= IDLE_SCLK;
      sclk_d <= IDLE_SCLK;
      cs_m   <= 1'b1;
      cs_s   <= 1'b1;
      cs_d   <= 1'b1;
      mosi_m <= 1'b0;
      mosi_s <= 1'b0;
    end else begin
      sclk_m <= sclk;
      sclk_s <= sclk_m;
      sclk_d <= sclk_s;
      cs_m   <= cs_n;
      cs_s   <= cs_m;
      cs_d   <= cs_s;
      mosi_m <= mosi;
      mosi_s <= mosi_m;
    end
  end

  // Edge pulses, field bookkeeping and address decode
  always_comb begin
    lead_edge   = IDLE_SCLK ? (~sclk_s & sclk_d) : (sclk_s & ~sclk_d);
    trail_edge  = IDLE_SCLK ? (sclk_s & ~sclk_d) : (~sclk_s & sclk_d);
    sample_edge = (CPHA != 0) ? trail_edge : lead_edge;
    drive_edge  = (CPHA != 0) ? lead_edge : trail_edge;
    cs_fall     = cs_d & ~cs_s;

    field_last = '0;
    case (state)
      CMD:          field_last = CNT_W'(7);
      ADDR:         field_last = CNT_W'(ADDR_WIDTH - 1);
      STRB:         field_last = CNT_W'(STRB_WIDTH - 1);
      WDATA, RDATA: field_last = CNT_W'(DATA_WIDTH - 1);
      default:      field_last = '0;
    endcase
    last_bit = sample_edge && (bit_cnt == field_last);

    sh_next  = {sh_in, mosi_s};
    cmd_byte = sh_next[7:0];
    cmd_ok   = (cmd_byte == 8'h02) || (cmd_byte == 8'h03);

    addr_inc   = addr + ADDR_WIDTH'(STRB_WIDTH);
    // The read fetch in ADDR must include the bit being sampled right now
    fetch_addr = (state == ADDR) ? sh_next[ADDR_WIDTH-1:0] : addr_inc;
    w_idx      = addr[BYTE_SH +: IDX_W];
    w_ok       = (addr >> (BYTE_SH + IDX_W)) == '0;
    f_idx      = fetch_addr[BYTE_SH +: IDX_W];
    f_ok       = (fetch_addr >> (BYTE_SH + IDX_W)) == '0;
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // FSM next-state logic; cs_n high aborts from any state
  always_comb begin
    state_n = state;
    if (cs_s) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE:  if (cs_fall)  state_n = CMD;
        CMD:   if (last_bit) state_n = cmd_ok ? ADDR : IGNORE;
        ADDR:  if (last_bit) state_n = is_write ? STRB : RDATA;
        STRB:  if (last_bit) state_n = WDATA;
        default: state_n = state;
      endcase
    end
  end

  // FSM outputs
  always_comb begin
    busy = ~cs_s;
    miso = (state == RDATA) & miso_q;
  end

  // Shift registers, memory commit/fetch and notification pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt   <= '0;
      sh_in     <= '0;
      sh_out    <= '0;
      is_write  <= 1'b0;
      addr      <= '0;
      strb      <= '0;
      miso_q    <= 1'b0;
      wr_pulse  <= 1'b0;
      wr_index  <= '0;
      err_pulse <= 1'b0;
      for (int unsigned i = 0; i < NUM_REGS; i++) mem[i] <= '0;
    end else begin
      wr_pulse  <= 1'b0;
      err_pulse <= 1'b0;

      if (state != RDATA) begin
        miso_q <= 1'b0;
      end else if (drive_edge) begin
        miso_q <= sh_out[DATA_WIDTH-1];
        sh_out <= {sh_out[DATA_WIDTH-2:0], 1'b0};
      end

      if (cs_s || state == IDLE) begin
        bit_cnt <= '0;
      end else if (sample_edge) begin
        sh_in   <= sh_next[SH_W-2:0];
        bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
        if (last_bit) begin
          case (state)
            CMD: begin
              is_write <= (cmd_byte == 8'h02);
              if (!cmd_ok) err_pulse <= 1'b1;
            end
            ADDR: begin
              addr <= sh_next[ADDR_WIDTH-1:0];
              if (!is_write) begin
                sh_out <= f_ok ? mem[f_idx] : '0;
                if (!f_ok) err_pulse <= 1'b1;
              end
            end
            STRB: strb <= sh_next[STRB_WIDTH-1:0];
            WDATA: begin
              if (w_ok) begin
                for (int unsigned k = 0; k < STRB_WIDTH; k++)
                  if (strb[k]) mem[w_idx][8*k +: 8] <= sh_next[8*k +: 8];
                wr_pulse <= 1'b1;
                wr_index <= w_idx;
              end else begin
                err_pulse <= 1'b1;
              end
              addr <= addr_inc;
            end
            RDATA: begin
              addr   <= addr_inc;
              sh_out <= f_ok ? mem[f_idx] : '0;
              if (!f_ok) err_pulse <= 1'b1;
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: doc/spi_slave_regfile.md
Name: spi_slave_regfile

Overview:
- Next-generation SPI slave register file, fully synchronous to a system clock. Replaces direct SCLK clocking with synchronised, oversampled SCLK/CS_N/MOSI.
- Adds a parametrised SPI mode (CPOL/CPHA), data width, register depth and strobe width.
- Adds burst auto-increment and write/error notification to local logic.
- Sits behind the AXI4-to-SPI bridge as the addressable target device.

Parameters:
- DATA_WIDTH, 32, word width; multiple of 8, range 8..64.
- ADDR_WIDTH, 32, byte-address field width on the wire.
- NUM_REGS, 256, number of words; power of 2.
- CPOL, 0, SCLK idle level.
- CPHA, 0, 0 = sample on leading edge, 1 = sample on trailing edge.
- STRB_WIDTH, DATA_WIDTH/8, byte strobe bits; derived, not overridable.

Ports:
- clk  in  1  system clock; frequency at least 4x SCLK.
- rst  in  1  asynchronous, active-high reset.
- sclk  in  1  SPI clock, asynchronous to clk.
- cs_n  in  1  SPI chip select, active low, asynchronous.
- mosi  in  1  SPI data in, MSB first.
- miso  out  1  SPI data out, MSB first.
- busy  out  1  high while a transaction is in progress (synchronised cs_n low).
- wr_pulse  out  1  one-clk pulse per committed word write.
- wr_index  out  log2(NUM_REGS)  word index of the last committed write.
- err_pulse  out  1  one-clk pulse on an out-of-range access or unknown command.

Behaviour:
- Reset: clk is the only clock. rst is asynchronous, active-high. On rst:
  - miso=0, busy=0, wr_pulse=0, wr_index=0, err_pulse=0.
  - FSM goes to IDLE.
  - All memory words are cleared to 0.
  - Synchroniser flops are set to their idle levels: sclk=CPOL, cs_n=1, mosi=0.
- Input synchronisation: sclk, cs_n and mosi each pass through a 2-flop synchroniser. An edge detector on the synchronised sclk yields one-clk lead_edge and trail_edge pulses. Leading edge is rising when CPOL=0, falling when CPOL=1.
- Sample edge = lead_edge if CPHA=0, else trail_edge. Drive edge = the other edge.
- Frame format, MSB first:
  - CMD: 8 bits.
  - ADDR: ADDR_WIDTH bits, byte address.
  - Writes only: STRB, STRB_WIDTH bits.
  - DATA: DATA_WIDTH bits per word, repeated for bursts.
- Commands: 0x02 = write, 0x03 = read. Any other value raises err_pulse once and enters IGNORE; miso stays 0 until cs_n rises.
- FSM states: IDLE, CMD, ADDR, STRB, WDATA, RDATA, IGNORE.
  - IDLE->CMD on the synchronised cs_n falling edge; bit counter cleared.
  - CMD->ADDR after 8 sample edges.
  - ADDR->STRB (write) or RDATA (read) after ADDR_WIDTH sample edges.
  - STRB->WDATA after STRB_WIDTH sample edges.
  - WDATA stays in WDATA after each word (burst).
  - RDATA stays in RDATA after each word (burst).
  - Any state->IDLE on synchronised cs_n high, regardless of bit position.
- Word index = addr >> log2(STRB_WIDTH). The address is in range iff index < NUM_REGS.
- Write commit: on the sample edge of the last data bit.
  - Each byte lane k with strb[k]=1 is written; other lanes are unchanged.
  - wr_pulse is asserted for 1 clk on the following cycle, and wr_index is updated.
  - If out of range: no write, err_pulse instead of wr_pulse.
  - The address then increments by STRB_WIDTH. STRB is sent once per frame and is reused for every burst word.
- Read fetch: on the sample edge of the last address bit, the word at the full address (including that bit) is loaded into the shift register.
  - Out of range loads 0 and raises err_pulse.
  - After each DATA_WIDTH bits shifted out, the address increments and the next word is loaded on that same sample edge.
- MISO timing:
  - miso is updated on drive edges while in RDATA.
  - CPHA=0: the MSB is presented on the first drive edge after the fetch, i.e. before the next sample edge.
  - CPHA=1: the MSB is presented on the leading edge of the first data bit.
  - miso=0 outside RDATA.
- Address wrap: increment is modulo 2^ADDR_WIDTH. A burst beyond NUM_REGS continues with the out-of-range rules above; there is no wrap into index 0.
- cs_n deasserted mid-word: the partial write word is discarded (no memory change, no wr_pulse) and the partial read is abandoned.
- Latency: any input edge is seen by the FSM 3 clk after the pin changes. wr_pulse occurs 1 clk after the commit edge.

Test Plan:
- Mode 0, write cmd 0x02, addr 0x10, strb 0xF, data 0xDEADBEEF, then read 0x03 addr 0x10 -> MISO returns 0xDEADBEEF; wr_pulse once with wr_index=4.
- Write strb 0x5, data 0x11223344 over existing 0xAABBCCDD at addr 0x0 -> readback 0xAA22CC44.
- Burst write of 3 words at addr 0x08, then burst read of 3 words from 0x08 -> words returned in order; 3 wr_pulses, wr_index=2,3,4.
- Loop over all four CPOL/CPHA combinations: write 0xA5A5_0F0F and read back -> identical data in every mode.
- Read addr 0x400 (index 256) and write to the same address -> MISO returns all 0, memory unchanged, err_pulse asserted per access, no wr_pulse.
- Raise cs_n after 20 write-data bits -> target word unchanged, FSM returns to IDLE, and the next frame decodes correctly. Also assert rst mid-frame -> all outputs 0 and memory cleared.
